// File: rtl/storage_access_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// storage_access_arbiter_pkg
// Shared types and constants for the storage access arbiter. The four
// requesters share one single-port chart/record BRAM.
//   - arb_state_e       : arbiter FSM states
//   - REQ_* constants   : requester index assignments
//   - is_writer/is_chart: decode a requester index into its role
// ----------------------------------------------------------------------------
package storage_access_arbiter_pkg;

  // Number of requesters and the width of a slot id.
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 8;

  // Requester indices. Bit 0 set means writer, bit 1 set means record storage.
  localparam logic [1:0] REQ_CHART_RD = 2'd0;
  localparam logic [1:0] REQ_CHART_WR = 2'd1;
  localparam logic [1:0] REQ_REC_RD   = 2'd2;
  localparam logic [1:0] REQ_REC_WR   = 2'd3;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_XFER  = 2'd1,
    ARB_DRAIN = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_e;

  // Writers are the odd requester indices.
  function automatic logic is_writer(input logic [1:0] req_idx);
    return req_idx[0];
  endfunction

  // Requesters 0 and 1 address the chart region, 2 and 3 the record region.
  function automatic logic is_chart(input logic [1:0] req_idx);
    return ~req_idx[1];
  endfunction

endpackage

// File: rtl/storage_access_arbiter_rr_picker.sv
// ----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector: finds the first asserted request at or
// after rr_ptr, wrapping modulo 4.
// Ports:
//   req    in  [3:0]  request vector
//   rr_ptr in  [1:0]  highest-priority index for this decision
//   found  out        at least one request is asserted
//   winner out [1:0]  selected requester (rr_ptr when nothing is found)
// ----------------------------------------------------------------------------
module rr_picker
  import storage_access_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         rr_ptr,
  output logic               found,
  output logic [1:0]         winner
);

  logic [1:0] cand;

  // Walk the four positions starting at rr_ptr; the 2-bit add gives the
  // modulo-4 wrap for free. The first hit wins.
  always_comb begin
    found  = 1'b0;
    winner = rr_ptr;
    cand   = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = rr_ptr + 2'(k);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/storage_access_arbiter.sv
// ----------------------------------------------------------------------------
// storage_access_arbiter
// Shares one single-port chart/record BRAM between four requesters
// (chart read, chart write, record read, record write). One whole slot
// (WORDS words) is transferred per grant, requesters are served round-robin,
// and slot id 0 means "no slot".
// Ports:
//   clk, sys_rst_n   clock, asynchronous active-low reset
//   req[4]           requests (0 chart rd, 1 chart wr, 2 record rd, 3 record wr)
//   req_id[4][8]     slot id per requester, sampled at grant
//   req_wdata[4][D]  writer data for the word currently at word_idx
//   gnt[4]           one-hot grant, held through XFER and DRAIN
//   word_idx         index of the word issued this cycle
//   wr_ack           a write word is committed this cycle
//   rdata, rdata_valid, rdata_idx   read return, RD_LAT after issue
//   done[4], err[4]  one-cycle completion / rejection pulses
//   mem_en, mem_we, mem_addr, mem_wdata, mem_rdata   BRAM port
// ----------------------------------------------------------------------------
module storage_access_arbiter
  import storage_access_arbiter_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 14,
  parameter int WORDS        = 64,
  parameter int CHART_BASE   = 0,
  parameter int CHART_SLOTS  = 16,
  parameter int RECORD_BASE  = 4096,
  parameter int RECORD_SLOTS = 32,
  parameter int RD_LAT       = 1,
  localparam int IDX_W       = $clog2(WORDS)
) (
  input  logic                             clk,
  input  logic                             sys_rst_n,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0][ID_W-1:0]     req_id,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [IDX_W-1:0]                 word_idx,
  output logic                             wr_ack,
  output logic [DATA_W-1:0]                rdata,
  output logic                             rdata_valid,
  output logic [IDX_W-1:0]                 rdata_idx,
  output logic [NUM_REQ-1:0]               done,
  output logic [NUM_REQ-1:0]               err,
  output logic                             mem_en,
  output logic                             mem_we,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic [DATA_W-1:0]                mem_wdata,
  input  logic [DATA_W-1:0]                mem_rdata
);

  localparam logic [ADDR_W-1:0] CHART_BASE_A  = ADDR_W'(CHART_BASE);
  localparam logic [ADDR_W-1:0] RECORD_BASE_A = ADDR_W'(RECORD_BASE);
  localparam logic [ID_W-1:0]   CHART_MAX_ID  = ID_W'(CHART_SLOTS);
  localparam logic [ID_W-1:0]   RECORD_MAX_ID = ID_W'(RECORD_SLOTS);
  localparam logic [IDX_W-1:0]  LAST_WORD     = IDX_W'(WORDS - 1);
  localparam logic [1:0]        LAST_DRAIN    = 2'(RD_LAT - 1);

  arb_state_e          state;
  logic [1:0]          rr_ptr;
  logic [1:0]          cur_idx;
  logic [ADDR_W-1:0]   slot_base;
  logic [IDX_W-1:0]    word_cnt;
  logic [1:0]          drain_cnt;
  logic                aborted;

  logic                pick_found;
  logic [1:0]          pick_winner;
  logic [ID_W-1:0]     pick_id;
  logic                pick_id_ok;
  logic [ADDR_W-1:0]   pick_base;

  logic                issuing;
  logic [NUM_REQ-1:0]  cur_onehot;

  logic [RD_LAT-1:0]   rd_valid_pipe;
  logic [IDX_W-1:0]    rd_idx_pipe [RD_LAT];

  rr_picker u_picker (
    .req    (req),
    .rr_ptr (rr_ptr),
    .found  (pick_found),
    .winner (pick_winner)
  );

  // Validate the winner's id against its region and precompute the slot's
  // first word address, so the FSM only has to latch it at grant time.
  always_comb begin
    pick_id    = req_id[pick_winner];
    pick_id_ok = (pick_id != '0) &&
                 (pick_id <= (is_chart(pick_winner) ? CHART_MAX_ID : RECORD_MAX_ID));
    pick_base  = (is_chart(pick_winner) ? CHART_BASE_A : RECORD_BASE_A) +
                 (ADDR_W'(pick_id - ID_W'(1)) << IDX_W);
  end

  // Arbiter FSM. err is a registered pulse; the rest of the visible state is
  // decoded from these registers below. A bad id keeps us in IDLE but still
  // advances rr_ptr so one stuck requester cannot starve the others. An
  // abort skips DONE so the requester sees neither done nor err.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ARB_IDLE;
      rr_ptr    <= 2'd0;
      cur_idx   <= 2'd0;
      slot_base <= '0;
      word_cnt  <= '0;
      drain_cnt <= 2'd0;
      aborted   <= 1'b0;
      err       <= '0;
    end else begin
      err <= '0;
      case (state)
        ARB_IDLE: begin
          if (pick_found) begin
            rr_ptr  <= pick_winner + 2'd1;
            cur_idx <= pick_winner;
            if (pick_id_ok) begin
              slot_base <= pick_base;
              word_cnt  <= '0;
              aborted   <= 1'b0;
              state     <= ARB_XFER;
            end else begin
              err <= NUM_REQ'(1) << pick_winner;
            end
          end
        end
        ARB_XFER: begin
          drain_cnt <= 2'd0;
          if (!req[cur_idx]) begin
            aborted  <= 1'b1;
            word_cnt <= '0;
            state    <= ARB_DRAIN;
          end else if (word_cnt == LAST_WORD) begin
            word_cnt <= '0;
            state    <= ARB_DRAIN;
          end else begin
            word_cnt <= word_cnt + IDX_W'(1);
          end
        end
        ARB_DRAIN: begin
          if (drain_cnt == LAST_DRAIN) begin
            state <= aborted ? ARB_IDLE : ARB_DONE;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        ARB_DONE: begin
          state <= ARB_IDLE;
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

  // BRAM port and handshakes. Issue is gated by the live req so a dropped
  // request stops the very cycle it falls, which is what makes aborts exact.
  always_comb begin
    cur_onehot  = NUM_REQ'(1) << cur_idx;
    issuing     = (state == ARB_XFER) && req[cur_idx];
    mem_en      = issuing;
    mem_we      = issuing && is_writer(cur_idx);
    wr_ack      = mem_we;
    mem_addr    = issuing ? (slot_base + ADDR_W'(word_cnt)) : '0;
    mem_wdata   = mem_we ? req_wdata[cur_idx] : '0;
    word_idx    = word_cnt;
    gnt         = ((state == ARB_XFER) || (state == ARB_DRAIN)) ? cur_onehot : '0;
    done        = (state == ARB_DONE) ? cur_onehot : '0;
    rdata_valid = rd_valid_pipe[RD_LAT-1];
    rdata_idx   = rd_idx_pipe[RD_LAT-1];
    rdata       = rdata_valid ? mem_rdata : '0;
  end

  // Read-return tracker: follows each read issue through the BRAM latency so
  // rdata_valid/rdata_idx line up with mem_rdata. Writes are not tracked.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd_valid_pipe <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        rd_idx_pipe[k] <= '0;
      end
    end else begin
      rd_valid_pipe[0] <= mem_en && !mem_we;
      rd_idx_pipe[0]   <= word_cnt;
      for (int k = 1; k < RD_LAT; k++) begin
        rd_valid_pipe[k] <= rd_valid_pipe[k-1];
        rd_idx_pipe[k]   <= rd_idx_pipe[k-1];
      end
    end
  end

endmodule

// File: tb/tb_storage_access_arbiter.sv
// ----------------------------------------------------------------------------
// tb_storage_access_arbiter
// Scoreboard bench for storage_access_arbiter: every expected BRAM access and
// read return is queued when a request is raised, then popped and compared
// when the DUT produces it. A behavioural BRAM with one cycle read latency
// sits on the memory port.
// ----------------------------------------------------------------------------
module tb_storage_access_arbiter;
  import storage_access_arbiter_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 14;
  localparam int WORDS  = 64;
  localparam int IDX_W  = 6;
  localparam int RD_LAT = 1;

  logic                           clk;
  logic                           sys_rst_n;
  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ-1:0][ID_W-1:0]   req_id;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]             gnt;
  logic [IDX_W-1:0]               word_idx;
  logic                           wr_ack;
  logic [DATA_W-1:0]              rdata;
  logic                           rdata_valid;
  logic [IDX_W-1:0]               rdata_idx;
  logic [NUM_REQ-1:0]             done;
  logic [NUM_REQ-1:0]             err;
  logic                           mem_en;
  logic                           mem_we;
  logic [ADDR_W-1:0]              mem_addr;
  logic [DATA_W-1:0]              mem_wdata;
  logic [DATA_W-1:0]              mem_rdata = '0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [31:0]       wdata;
  } acc_t;

  typedef struct {
    logic [31:0]      data;
    logic [IDX_W-1:0] idx;
  } rd_t;

  acc_t        acc_q[$];
  rd_t         rd_q[$];
  acc_t        mon_acc;
  rd_t         mon_rd;
  logic [31:0] bram [1 << ADDR_W];
  bit          preloaded = 1'b0;
  int          checks    = 0;
  int          failures  = 0;
  int          cycle     = 0;
  int          ack_count = 0;
  int          t;
  int          a0;

  storage_access_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .WORDS(WORDS), .CHART_BASE(0),
    .CHART_SLOTS(16), .RECORD_BASE(4096), .RECORD_SLOTS(32), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .req(req), .req_id(req_id),
    .req_wdata(req_wdata), .gnt(gnt), .word_idx(word_idx), .wr_ack(wr_ack),
    .rdata(rdata), .rdata_valid(rdata_valid), .rdata_idx(rdata_idx),
    .done(done), .err(err), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Initial BRAM contents, a function of the address.
  function automatic logic [31:0] pattern(input int a);
    return (32'(a) * 32'h0001_0003) ^ 32'hC3C3_0000;
  endfunction

  // Data each writer supplies for word k of its slot.
  function automatic logic [31:0] writerData(input int r, input int k);
    return (r == 1) ? (32'(k) + 32'h1000) : (32'(k) * 32'd5);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h want=0x%0h (cycle %0d)", tag, got, want, cycle);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Writers present data for whatever word the arbiter is issuing.
  always_comb begin
    req_wdata    = '0;
    req_wdata[1] = writerData(1, int'(word_idx));
    req_wdata[3] = writerData(3, int'(word_idx));
  end

  // Behavioural BRAM, one cycle read latency.
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int a = 0; a < (1 << ADDR_W); a++) bram[a] <= pattern(a);
      preloaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= bram[mem_addr];
    end
  end

  // Scoreboard side: compare every BRAM access and every read return.
  always @(negedge clk) begin
    if (mem_en === 1'b1) begin
      if (acc_q.size() == 0) begin
        checkOutput("unexpected_mem_en", 32'(mem_en), 32'd0);
      end else begin
        mon_acc = acc_q.pop_front();
        checkOutput("mem_addr", 32'(mem_addr), 32'(mon_acc.addr));
        checkOutput("mem_we", 32'(mem_we), 32'(mon_acc.we));
        checkOutput("wr_ack", 32'(wr_ack), 32'(mon_acc.we));
        if (mon_acc.we) checkOutput("mem_wdata", mem_wdata, mon_acc.wdata);
      end
    end
    if (wr_ack === 1'b1) ack_count++;
    if (rdata_valid === 1'b1) begin
      if (rd_q.size() == 0) begin
        checkOutput("unexpected_rdata_valid", 32'(rdata_valid), 32'd0);
      end else begin
        mon_rd = rd_q.pop_front();
        checkOutput("rdata", rdata, mon_rd.data);
        checkOutput("rdata_idx", 32'(rdata_idx), 32'(mon_rd.idx));
      end
    end
  end

  task automatic nextDrive();
    @(posedge clk);
    #1;
  endtask

  // Queue the expected accesses of one transfer and raise the request.
  task automatic applyStimulus(input int r, input int id, input int nwords, input int nreads);
    int base;
    base = ((r < 2) ? 0 : 4096) + (id - 1) * WORDS;
    for (int k = 0; k < nwords; k++)
      acc_q.push_back('{addr: ADDR_W'(base + k), we: (r % 2 == 1),
                        wdata: (r % 2 == 1) ? writerData(r, k) : 32'd0});
    if (r % 2 == 0)
      for (int k = 0; k < nreads; k++)
        rd_q.push_back('{data: pattern(base + k), idx: IDX_W'(k)});
    req_id[r] = 8'(id);
    req[r]    = 1'b1;
  endtask

  task automatic waitGnt(input int r, input int want_cycle);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt === 4'b0000 && n < 300);
    if (gnt !== 4'b0000) begin
      checkOutput("gnt_cycle", 32'(cycle), 32'(want_cycle));
      checkOutput("gnt_onehot", 32'(gnt), 32'd1 << r);
      checkOutput("first_word_idx", 32'(word_idx), 32'd0);
    end else begin
      checkOutput("gnt_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic waitDone(input int r, input int want_cycle, input bit drop);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done[r] !== 1'b1 && n < 300);
    if (done[r] === 1'b1) begin
      checkOutput("done_cycle", 32'(cycle), 32'(want_cycle));
      checkOutput("done_onehot", 32'(done), 32'd1 << r);
      checkOutput("gnt_low_in_done", 32'(gnt), 32'd0);
      if (drop) req[r] = 1'b0;
    end else begin
      checkOutput("done_timeout", 32'd0, 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    sys_rst_n = 1'b0;
    req       = '0;
    req_id    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_gnt", 32'(gnt), 32'd0);
    checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_rdata_valid", 32'(rdata_valid), 32'd0);
    checkOutput("rst_word_idx", 32'(word_idx), 32'd0);
    @(posedge clk);
    #1 sys_rst_n = 1'b1;

    $display("[TB] chart read, id 3");
    nextDrive();
    applyStimulus(0, 3, WORDS, WORDS);
    t = cycle;
    waitGnt(0, t + 1);
    checkOutput("first_addr", 32'(mem_addr), 32'd128);
    checkOutput("rvalid_before_latency", 32'(rdata_valid), 32'd0);
    @(negedge clk);
    checkOutput("first_rvalid", 32'(rdata_valid), 32'd1);
    checkOutput("first_rdata_idx", 32'(rdata_idx), 32'd0);
    waitDone(0, t + 1 + WORDS + RD_LAT, 1'b1);
    checkOutput("rd_q_drained", 32'(rd_q.size()), 32'd0);

    $display("[TB] record write, id 1");
    a0 = ack_count;
    nextDrive();
    applyStimulus(3, 1, WORDS, 0);
    t = cycle;
    waitGnt(3, t + 1);
    waitDone(3, t + 66, 1'b1);
    checkOutput("wr_ack_count", 32'(ack_count - a0), 32'd64);
    for (int k = 0; k < WORDS; k++)
      checkOutput("bram_record", bram[4096 + k], 32'(5 * k));

    $display("[TB] contention, all four held");
    nextDrive();
    applyStimulus(0, 2, WORDS, WORDS);
    applyStimulus(1, 4, WORDS, 0);
    applyStimulus(2, 5, WORDS, WORDS);
    applyStimulus(3, 32, WORDS, 0);
    applyStimulus(0, 2, WORDS, WORDS);
    t = cycle;
    for (int n = 0; n < 5; n++) begin
      waitGnt(n % 4, t + 1 + 67 * n);
      waitDone(n % 4, t + 66 + 67 * n, 1'b0);
    end
    req = '0;
    repeat (2) @(negedge clk);
    checkOutput("contention_no_regrant", 32'(gnt), 32'd0);
    checkOutput("contention_acc_q_empty", 32'(acc_q.size()), 32'd0);
    checkOutput("contention_rd_q_empty", 32'(rd_q.size()), 32'd0);

    $display("[TB] bad ids");
    for (int b = 0; b < 3; b++) begin
      int r;
      int id;
      r  = (b == 2) ? 0 : 2;
      id = (b == 0) ? 0 : ((b == 1) ? 33 : 17);
      nextDrive();
      req_id[r] = 8'(id);
      req[r]    = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checkOutput("bad_id_err", 32'(err), 32'd1 << r);
      checkOutput("bad_id_gnt", 32'(gnt), 32'd0);
      checkOutput("bad_id_mem_en", 32'(mem_en), 32'd0);
      req[r] = 1'b0;
      @(negedge clk);
      checkOutput("bad_id_err_pulse", 32'(err), 32'd0);
    end

    $display("[TB] abort chart write at word 10");
    a0 = ack_count;
    nextDrive();
    applyStimulus(1, 5, 10, 0);
    t = cycle;
    repeat (11) @(posedge clk);
    #1 req[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("abort_no_done", 32'(done), 32'd0);
      checkOutput("abort_no_err", 32'(err), 32'd0);
      if (cycle >= t + 13) checkOutput("abort_idle_gnt", 32'(gnt), 32'd0);
    end
    checkOutput("abort_ack_count", 32'(ack_count - a0), 32'd10);
    for (int k = 0; k < 10; k++)
      checkOutput("abort_written", bram[256 + k], 32'(k) + 32'h1000);
    checkOutput("abort_untouched", bram[266], pattern(266));
    checkOutput("abort_acc_q_empty", 32'(acc_q.size()), 32'd0);

    $display("[TB] reset during transfer");
    nextDrive();
    applyStimulus(0, 1, 20, 19);
    t = cycle;
    repeat (21) @(posedge clk);
    #1;
    sys_rst_n = 1'b0;
    req[0]    = 1'b0;
    #1;
    checkOutput("midrst_gnt", 32'(gnt), 32'd0);
    checkOutput("midrst_mem_en", 32'(mem_en), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_err", 32'(err), 32'd0);
    checkOutput("midrst_rdata_valid", 32'(rdata_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 sys_rst_n = 1'b1;
    checkOutput("midrst_acc_q_empty", 32'(acc_q.size()), 32'd0);
    checkOutput("midrst_rd_q_empty", 32'(rd_q.size()), 32'd0);
    nextDrive();
    applyStimulus(0, 3, WORDS, WORDS);
    t = cycle;
    waitGnt(0, t + 1);
    waitDone(0, t + 66, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("final_acc_q_empty", 32'(acc_q.size()), 32'd0);
    checkOutput("final_rd_q_empty", 32'(rd_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
